led_acc_fx: RTL and testbench

- Parametrised LED "stacking" effect generator: a single lit dot enters at one end of a WIDTH-LED bar and travels toward the far end.
- Each dot stops on top of the growing stack; when the bar is full it holds, then drains (optional) or clears, and the effect loops.
- Successor to the fixed 8-LED accumulate effect, adding:
  - arbitrary width;
  - a step prescaler;
  - selectable direction;
  - enable/freeze;
  - stack-level output;
  - an end-of-cycle pulse.
- Sits between the board clock and the LED pins of the Led_Effect designs.

---
 rtl/led_acc_fx.sv | 127 ++++++++++++
 tb/tb_led_acc_fx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/led_acc_fx.sv
// led_acc_fx: LED stacking effect, a dot travels and piles up into a full bar, then clears.
// Define LED_ACC_DRAIN_EN to drain the full bar one LED per step instead of clearing it at once.
module led_acc_fx #(
  parameter int WIDTH      = 8,
  parameter int TICK_DIV   = 1,
  parameter int HOLD_STEPS = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       dir,
  output logic [WIDTH-1:0]           q,
  output logic [$clog2(WIDTH+1)-1:0] level,
  output logic                       cycle_done
);
  localparam int LW = $clog2(WIDTH+1);
  localparam int PW = $clog2(WIDTH);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int HW = HOLD_STEPS > 0 ? $clog2(HOLD_STEPS+1) : 1;
  typedef enum logic [1:0] {
    FILL,
    HOLD
`ifdef LED_ACC_DRAIN_EN
    , DRAIN
`endif
  } state_t;
  state_t st, st_n;
  logic [LW-1:0] k, k_n;
  logic [PW-1:0] p, p_n;
  logic [HW-1:0] h, h_n;
  logic [CW-1:0] pc;
  logic dot, dot_n, dir_r, dr_n, done_n, step;
  logic [WIDTH-1:0] fr_n, q_n;
  assign step  = en && int'(pc) == TICK_DIV - 1;
  assign level = k;
  always_comb begin
    st_n   = st;
    k_n    = k;
    p_n    = p;
    dot_n  = dot;
    h_n    = h;
    dr_n   = dir_r;
    done_n = 1'b0;
    if (step) begin
      case (st)
        FILL: begin
          if (!dot) begin
            dot_n = 1'b1;
            p_n   = '0;
            dr_n  = k == '0 ? dir : dir_r;
          end else if (int'(p) != WIDTH - 1 - int'(k)) begin
            p_n = p + 1'b1;
          end else begin
            k_n = k + 1'b1;
            p_n = '0;
            if (int'(k) == WIDTH - 1) begin
              dot_n = 1'b0;
              h_n   = '0;
              st_n  = HOLD;
            end
          end
        end
        HOLD: begin
          if (int'(h) == HOLD_STEPS) begin
`ifdef LED_ACC_DRAIN_EN
            st_n = DRAIN;
            k_n  = k - 1'b1;
`else
            st_n   = FILL;
            k_n    = '0;
            done_n = 1'b1;
`endif
          end else begin
            h_n = h + 1'b1;
          end
        end
`ifdef LED_ACC_DRAIN_EN
        DRAIN: begin
          k_n = k - 1'b1;
          if (int'(k) == 1) begin
            st_n   = FILL;
            done_n = 1'b1;
          end
        end
`endif
        default: st_n = FILL;
      endcase
    end
  end
  // q is rebuilt from the next state every clock; between steps that reproduces the current q
  always_comb begin
    fr_n = '0;
    q_n  = '0;
    for (int i = 0; i < WIDTH; i++)
      fr_n[i] = st_n == HOLD
             || (st_n == FILL && (i >= WIDTH - int'(k_n) || (dot_n && int'(p_n) == i)))
`ifdef LED_ACC_DRAIN_EN
             || (st_n == DRAIN && i < int'(k_n))
`endif
             ;
    for (int i = 0; i < WIDTH; i++)
      q_n[i] = dr_n ? fr_n[WIDTH-1-i] : fr_n[i];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= FILL;
      k          <= '0;
      p          <= '0;
      h          <= '0;
      pc         <= '0;
      dot        <= 1'b0;
      dir_r      <= 1'b0;
      q          <= '0;
      cycle_done <= 1'b0;
    end else begin
      st         <= st_n;
      k          <= k_n;
      p          <= p_n;
      h          <= h_n;
      pc         <= en ? (step ? '0 : pc + 1'b1) : pc;
      dot        <= dot_n;
      dir_r      <= dr_n;
      q          <= q_n;
      cycle_done <= done_n;
    end
  end
endmodule

// File: tb/tb_led_acc_fx.sv
// tb_led_acc_fx: directed checks of led_acc_fx at WIDTH=8 (TICK_DIV 1 and 3) and WIDTH=2.
module tb_led_acc_fx;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic r8 = 1'b1, e8 = 1'b1, d8 = 1'b0, c8;
  logic r3 = 1'b1, e3 = 1'b1, d3 = 1'b0, c3;
  logic r2 = 1'b1, e2 = 1'b1, d2 = 1'b0, c2;
  logic [7:0] q8, q3;
  logic [3:0] l8, l3;
  logic [1:0] q2, l2;
  led_acc_fx #(.WIDTH(8), .TICK_DIV(1), .HOLD_STEPS(2)) u8 (
    .clk(clk), .reset(r8), .en(e8), .dir(d8), .q(q8), .level(l8), .cycle_done(c8));
  led_acc_fx #(.WIDTH(8), .TICK_DIV(3), .HOLD_STEPS(2)) u3 (
    .clk(clk), .reset(r3), .en(e3), .dir(d3), .q(q3), .level(l3), .cycle_done(c3));
  led_acc_fx #(.WIDTH(2), .TICK_DIV(1), .HOLD_STEPS(2)) u2 (
    .clk(clk), .reset(r2), .en(e2), .dir(d2), .q(q2), .level(l2), .cycle_done(c2));
`ifdef LED_ACC_DRAIN_EN
  localparam int END8 = 47;
  localparam int N2 = 8;
  logic [1:0] w2q [8] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd0};
  logic [1:0] w2l [8] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0};
`else
  localparam int END8 = 40;
  localparam int N2 = 7;
  logic [1:0] w2q [8] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
  logic [1:0] w2l [8] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
`endif
  int total = 0, bad = 0;
  logic [7:0] exp_q [37];
  logic [3:0] exp_l [37];
  logic [7:0] full = 8'hFF;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tk(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    int n = 0;
    for (int k = 0; k < 8; k++)
      for (int p = 0; p < 8 - k; p++) begin
        exp_q[n] = ~(full >> k) | (8'd1 << p);
        exp_l[n] = 4'(k);
        n++;
      end
    exp_q[36] = 8'hFF;
    exp_l[36] = 4'd8;
    tk;
    chk("rst_q", q8, 0);
    chk("rst_level", l8, 0);
    chk("rst_done", c8, 0);
    chk("rst_q_td3", q3, 0);
    chk("rst_q_w2", q2, 0);
    r8 = 1'b0;
    for (int s = 1; s <= 37; s++) begin
      tk;
      chk($sformatf("fill_q_%0d", s), q8, exp_q[s-1]);
      chk($sformatf("fill_lvl_%0d", s), l8, exp_l[s-1]);
    end
    tk;
    chk("hold38_q", q8, 8'hFF);
    chk("hold38_done", c8, 0);
    tk;
    chk("hold39_q", q8, 8'hFF);
    chk("hold39_lvl", l8, 8);
`ifdef LED_ACC_DRAIN_EN
    for (int s = 40; s <= 47; s++) begin
      tk;
      chk($sformatf("drain_q_%0d", s), q8, 8'hFF >> (s - 39));
      chk($sformatf("drain_lvl_%0d", s), l8, 8 - (s - 39));
      chk($sformatf("drain_done_%0d", s), c8, s == 47);
    end
`else
    tk;
    chk("clear_q", q8, 0);
    chk("clear_lvl", l8, 0);
    chk("clear_done", c8, 1);
`endif
    tk;
    chk("respawn_q", q8, 8'h01);
    chk("respawn_done", c8, 0);
    r8 = 1'b1;
    tk;
    r8 = 1'b0;
    tk(24);
    chk("pre_rst_q", q8, 8'hE4);
    r8 = 1'b1;
    tk;
    chk("midrst_q", q8, 0);
    chk("midrst_lvl", l8, 0);
    r8 = 1'b0;
    tk;
    chk("post_rst_q", q8, 8'h01);
    r8 = 1'b1;
    d8 = 1'b1;
    tk;
    r8 = 1'b0;
    for (int s = 1; s <= 8; s++) begin
      tk;
      chk($sformatf("dir1_q_%0d", s), q8, 8'h80 >> (s - 1));
    end
    tk;
    chk("dir1_q_9", q8, 8'h81);
    tk(10);
    d8 = 1'b0;
    tk;
    chk("dir1_q_20", q8, 8'h0B);
    tk(17);
    chk("dir1_full", q8, 8'hFF);
    tk(END8 - 37);
    chk("dir1_end_q", q8, 0);
    chk("dir1_end_done", c8, 1);
    tk;
    chk("dir_relatch_q", q8, 8'h01);
    r3 = 1'b0;
    tk;
    chk("td3_c1", q3, 0);
    tk;
    chk("td3_c2", q3, 0);
    tk;
    chk("td3_c3", q3, 8'h01);
    tk(2);
    chk("td3_c5", q3, 8'h01);
    tk;
    chk("td3_c6", q3, 8'h02);
    tk;
    e3 = 1'b0;
    tk(10);
    chk("frz_q", q3, 8'h02);
    chk("frz_lvl", l3, 0);
    e3 = 1'b1;
    tk;
    chk("resume1_q", q3, 8'h02);
    tk;
    chk("resume2_q", q3, 8'h04);
    for (int i = 0; i < 400 && !c3; i++) tk;
    chk("td3_done_seen", c3, 1);
    chk("td3_done_q", q3, 0);
    tk;
    chk("td3_done_pulse", c3, 0);
    chk("td3_after_q", q3, 0);
    tk(2);
    chk("td3_respawn_q", q3, 8'h01);
    r2 = 1'b0;
    for (int s = 1; s <= N2; s++) begin
      tk;
      chk($sformatf("w2_q_%0d", s), q2, w2q[s-1]);
      chk($sformatf("w2_lvl_%0d", s), l2, w2l[s-1]);
      chk($sformatf("w2_done_%0d", s), c2, s == N2);
    end
    tk;
    chk("w2_respawn_q", q2, 2'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
